// File: rtl/fta_io_timeout32_pkg.sv
// Shared types for the FTA 32-bit I/O timeout watchdog.
//   - fta_cmd_request32_t  : registered request coming out of the 256-to-32 bridge
//   - fta_cmd_response32_t : response channel format, also used for the device responses
//   - fta_tmo_state_t      : watchdog FSM states
//   - FTA_IO_ERR_DATA      : default data returned with an error response
//   - io_hit()             : decodes whether a request falls inside the monitored I/O window
package fta_io_timeout32_pkg;

    typedef logic [7:0] fta_tranid_t;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        fta_tranid_t tid;
        logic [31:0] padr;
        logic [31:0] dat;
    } fta_cmd_request32_t;

    typedef struct packed {
        fta_tranid_t tid;
        logic        stall;
        logic        next;
        logic        ack;
        logic        rty;
        logic        err;
        logic [3:0]  pri;
        logic [31:0] adr;
        logic [31:0] dat;
    } fta_cmd_response32_t;

    typedef enum logic [1:0] {IDLE, WAIT, ERR, DONE} fta_tmo_state_t;

    localparam logic [31:0] FTA_IO_ERR_DATA = 32'hDEADBEEF;

    // An active strobe whose masked address matches the masked window base.
    // The bridge's idle pattern has cyc low, so it can never hit.
    function automatic logic io_hit(input fta_cmd_request32_t r,
                                    input logic [31:0]        base,
                                    input logic [31:0]        mask);
        return r.cyc & r.stb & ((r.padr & mask) == (base & mask));
    endfunction

endpackage

// File: rtl/fta_io_timeout32_if.sv
// Signal bundle between the bridge side and the timeout watchdog.
//   req       : registered request from the bridge (snooped)
//   chresp    : device response channels (snooped)
//   resp      : watchdog's own response channel into the bridge merge
//   tmo_count : saturating timeout count
//   busy      : a request is being timed
// Modports: master = bridge/environment side, slave = watchdog side.
interface fta_io_timeout32_if #(
    parameter int CHANNELS = 2
) ();
    import fta_io_timeout32_pkg::*;

    fta_cmd_request32_t                 req;
    fta_cmd_response32_t [CHANNELS-1:0] chresp;
    fta_cmd_response32_t                resp;
    logic [15:0]                        tmo_count;
    logic                               busy;

    modport master (
        output req,
        output chresp,
        input  resp,
        input  tmo_count,
        input  busy
    );

    modport slave (
        input  req,
        input  chresp,
        output resp,
        output tmo_count,
        output busy
    );

endinterface

// File: rtl/fta_io_timeout32.sv
// Bus-error watchdog for the 32-bit FTA I/O side.
// Watches the bridge's registered request; when an in-window request gets no
// tid-matching device answer within TIMEOUT cycles, it emits a one-cycle error
// response (ack+err) carrying the captured tid/address so the CPU never stalls
// on unmapped or hung I/O.
// Ports:
//   clk_i     : system clock
//   rst_i     : synchronous active-high reset
//   bus       : slave modport - req/chresp in, resp/tmo_count/busy out
// All outputs are registered.
module fta_io_timeout32
    import fta_io_timeout32_pkg::*;
#(
    parameter int          CHANNELS = 2,
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] IO_BASE  = 32'hFED00000,
    parameter logic [31:0] IO_MASK  = 32'hFFF00000,
    parameter logic [31:0] ERR_DATA = FTA_IO_ERR_DATA
) (
    input  logic               clk_i,
    input  logic               rst_i,
    fta_io_timeout32_if.slave  bus
);

    // Counter only has to reach TIMEOUT-1, so this width can never wrap.
    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    fta_tmo_state_t      state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    fta_tranid_t         tid_q, tid_d;
    logic [31:0]         adr_q, adr_d;
    logic [15:0]         tmo_q, tmo_d;
    logic                busy_q, busy_d;
    fta_cmd_response32_t resp_q, resp_d;

    logic hit;
    logic answered;

    assign hit = io_hit(bus.req, IO_BASE, IO_MASK);

    // Any channel answering our tid ends the wait; the channel index is
    // irrelevant because the device behind a given slot is not known here.
    always_comb begin
        answered = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if ((bus.chresp[i].ack | bus.chresp[i].err | bus.chresp[i].rty) &&
                (bus.chresp[i].tid == tid_q))
                answered = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tid_d   = tid_q;
        adr_d   = adr_q;
        tmo_d   = tmo_q;
        resp_d  = '0;

        case (state_q)
            IDLE: begin
                if (hit) begin
                    tid_d   = bus.req.tid;
                    adr_d   = bus.req.padr;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Answer is checked first so an answer racing the timeout wins.
                if (answered)
                    state_d = DONE;
                else if (!bus.req.cyc)
                    state_d = IDLE;
                else if (cnt_q == LAST)
                    state_d = ERR;
                else
                    cnt_d = cnt_q + CW'(1);
            end
            ERR: begin
                state_d = DONE;
            end
            DONE: begin
                // Hold off until the upstream cycle closes so a request the
                // bridge keeps re-registering is only timed once.
                if (!bus.req.cyc)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Response is built from the next state so it lines up with ERR
        // while still coming straight out of a flop.
        if (state_d == ERR) begin
            resp_d.ack = 1'b1;
            resp_d.err = 1'b1;
            resp_d.tid = tid_q;
            resp_d.adr = adr_q;
            resp_d.dat = ERR_DATA;
            if (tmo_q != 16'hFFFF)
                tmo_d = tmo_q + 16'd1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tid_q   <= '0;
            adr_q   <= '0;
            tmo_q   <= '0;
            busy_q  <= 1'b0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tid_q   <= tid_d;
            adr_q   <= adr_d;
            tmo_q   <= tmo_d;
            busy_q  <= busy_d;
            resp_q  <= resp_d;
        end
    end

    assign bus.resp      = resp_q;
    assign bus.tmo_count = tmo_q;
    assign bus.busy      = busy_q;

    // Write data, byte selects and the non-handshake response fields are
    // carried on the shared bundle but play no part in timing.
    logic unused_bits;
    assign unused_bits = ^{bus.req.we, bus.req.sel, bus.req.dat, bus.chresp};

endmodule
